// File: rtl/drbg_pkg.sv
// rtl/drbg_pkg.sv - shared types and default parameters for the DRBG entropy source
package drbg_pkg;

   typedef enum logic [2:0] {
      STARTUP,
      IDLE,
      COLLECT,
      DELIVER,
      FAILED
   } ent_state_t;

   localparam int DEF_SAMPLE_W        = 8;
   localparam int DEF_OUT_W           = 128;
   localparam int DEF_RCT_CUTOFF      = 5;
   localparam int DEF_APT_WINDOW      = 64;
   localparam int DEF_APT_CUTOFF      = 40;
   localparam int DEF_STARTUP_SAMPLES = 64;

endpackage

// File: rtl/drbg_entropy_source_if.sv
// rtl/drbg_entropy_source_if.sv - noise input, entropy handshake and status signals
interface drbg_entropy_source_if
   import drbg_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W,
   parameter int OUT_W    = DEF_OUT_W
);
   logic                noise_valid;
   logic [SAMPLE_W-1:0] noise_sample;
   logic                ent_req;
   logic                ent_ack;
   logic                ent_valid;
   logic [OUT_W-1:0]    ent_data;
   logic                startup_done;
   logic                catastrophic_error_flag;

   modport master (
      output noise_valid, noise_sample, ent_req, ent_ack,
      input  ent_valid, ent_data, startup_done, catastrophic_error_flag
   );

   modport slave (
      input  noise_valid, noise_sample, ent_req, ent_ack,
      output ent_valid, ent_data, startup_done, catastrophic_error_flag
   );
endinterface

// File: rtl/drbg_health_test.sv
// rtl/drbg_health_test.sv - repetition count and adaptive proportion tests
// o_fail is combinational and judges the sample presented this cycle.
module drbg_health_test
   import drbg_pkg::*;
#(
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sample_valid,
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic                o_fail
);
   localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
   localparam int APT_W = $clog2(APT_WINDOW + 1);
   localparam int WIN_W = $clog2(APT_WINDOW + 1);
   localparam logic [RCT_W-1:0] RCT_LIM  = RCT_W'(RCT_CUTOFF);
   localparam logic [APT_W-1:0] APT_LIM  = APT_W'(APT_CUTOFF);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(APT_WINDOW - 1);

   logic [SAMPLE_W-1:0] r_prev;
   logic [SAMPLE_W-1:0] r_ref;
   logic                r_have_prev;
   logic [RCT_W-1:0]    r_run;
   logic [APT_W-1:0]    r_match;
   logic [WIN_W-1:0]    r_win;

   logic [RCT_W-1:0]    w_run_next;
   logic [APT_W-1:0]    w_match_next;
   logic                w_new_win;

   always_comb begin
      w_new_win    = (r_win == '0);
      w_run_next   = (r_have_prev && (i_sample == r_prev)) ? r_run + RCT_W'(1) : RCT_W'(1);
      w_match_next = w_new_win ? APT_W'(1) : r_match + APT_W'(i_sample == r_ref);
      o_fail       = i_sample_valid && ((w_run_next >= RCT_LIM) || (w_match_next >= APT_LIM));
   end

   // r_win counts samples already in the current window; zero means the next one opens a new window.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_prev      <= '0;
         r_ref       <= '0;
         r_have_prev <= 1'b0;
         r_run       <= '0;
         r_match     <= '0;
         r_win       <= '0;
      end else if (i_sample_valid) begin
         r_prev      <= i_sample;
         r_have_prev <= 1'b1;
         r_run       <= w_run_next;
         r_match     <= w_match_next;
         if (w_new_win) r_ref <= i_sample;
         r_win       <= (r_win == WIN_LAST) ? '0 : r_win + WIN_W'(1);
      end
   end

endmodule

// File: rtl/drbg_entropy_source.sv
// rtl/drbg_entropy_source.sv - health-tested noise packer feeding the DRBG instantiate stage
// Any health failure parks the FSM in FAILED until reset.
module drbg_entropy_source
   import drbg_pkg::*;
#(
   parameter int SAMPLE_W        = DEF_SAMPLE_W,
   parameter int OUT_W           = DEF_OUT_W,
   parameter int RCT_CUTOFF      = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW      = DEF_APT_WINDOW,
   parameter int APT_CUTOFF      = DEF_APT_CUTOFF,
   parameter int STARTUP_SAMPLES = DEF_STARTUP_SAMPLES
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   drbg_entropy_source_if.slave ent_if
);
   localparam int WORDS   = OUT_W / SAMPLE_W;
   localparam int CNT_MAX = (STARTUP_SAMPLES > WORDS) ? STARTUP_SAMPLES : WORDS;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_SAMPLES - 1);
   localparam logic [CNT_W-1:0] WORD_LAST    = CNT_W'(WORDS - 1);

   ent_state_t       r_state;
   ent_state_t       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [OUT_W-1:0] r_data;
   logic             r_startup_done;
   logic             w_test_valid;
   logic             w_fail;

   assign w_test_valid = ent_if.noise_valid && (r_state != FAILED);

   drbg_health_test #(
      .SAMPLE_W   (SAMPLE_W),
      .RCT_CUTOFF (RCT_CUTOFF),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_health (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_sample_valid (w_test_valid),
      .i_sample       (ent_if.noise_sample),
      .o_fail         (w_fail)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= STARTUP;
      else          r_state <= w_next;
   end

   // A health failure outranks every other transition, including an ack in DELIVER.
   always_comb begin
      w_next = r_state;
      case (r_state)
         STARTUP: begin
            if (w_fail) w_next = FAILED;
            else if (w_test_valid && (r_cnt == STARTUP_LAST)) w_next = IDLE;
         end
         IDLE: begin
            if (w_fail) w_next = FAILED;
            else if (ent_if.ent_req) w_next = COLLECT;
         end
         COLLECT: begin
            if (w_fail) w_next = FAILED;
            else if (w_test_valid && (r_cnt == WORD_LAST)) w_next = DELIVER;
         end
         DELIVER: begin
            if (w_fail) w_next = FAILED;
            else if (ent_if.ent_ack) w_next = IDLE;
         end
         FAILED:  w_next = FAILED;
         default: w_next = FAILED;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt          <= '0;
         r_data         <= '0;
         r_startup_done <= 1'b0;
      end else begin
         case (r_state)
            STARTUP: begin
               if (w_next == IDLE) begin
                  r_cnt          <= '0;
                  r_startup_done <= 1'b1;
               end else if (w_test_valid) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            IDLE: if (w_next == COLLECT) r_cnt <= '0;
            COLLECT: begin
               if (w_test_valid && !w_fail) begin
                  r_data <= {r_data[OUT_W-SAMPLE_W-1:0], ent_if.noise_sample};
                  r_cnt  <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
         if ((w_next == FAILED) || ((r_state == DELIVER) && (w_next == IDLE))) r_data <= '0;
      end
   end

   assign ent_if.ent_valid               = (r_state == DELIVER);
   assign ent_if.ent_data                = r_data;
   assign ent_if.startup_done            = r_startup_done;
   assign ent_if.catastrophic_error_flag = (r_state == FAILED);

endmodule
